// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage miniLA pipeline: load-use bubbles, branch
// redirects, multi-cycle MDU occupancy and data-memory wait, plus a stall counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned MDU_LAT = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic [4:0]       id_rj,
    input  logic [4:0]       id_rk,
    input  logic             id_rj_used,
    input  logic             id_rk_used,
    input  logic             ex_is_load,
    input  logic             ex_wr_en,
    input  logic [4:0]       ex_rd,
    input  logic             ex_br_taken,
    input  logic             ex_mdu_start,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pipeline_stop,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             stall_ex,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned MDU_W = 8;

    localparam logic [1:0] ST_RUN = 2'd0;
    localparam logic [1:0] ST_MDU = 2'd1;
    localparam logic [1:0] ST_MEM = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [MDU_W-1:0] mdu_cnt;
    logic [MDU_W-1:0] mdu_cnt_nxt;
    logic             load_use;
    logic             mem_wait;
    logic             rj_hit;
    logic             rk_hit;

    assign rj_hit   = id_rj_used && (id_rj == ex_rd);
    assign rk_hit   = id_rk_used && (id_rk == ex_rd);
    assign load_use = ex_is_load && ex_wr_en && (ex_rd != 5'd0) && (rj_hit || rk_hit);
    assign mem_wait = mem_req && !mem_ack;

    // Next-state and control outputs; branch/load-use are simply not acted on while
    // stalled, since the held EX/ID contents re-present them after release.
    always_comb begin
        state_nxt     = state;
        mdu_cnt_nxt   = mdu_cnt;
        pipeline_stop = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        stall_ex      = 1'b0;
        case (state)
            ST_RUN: begin
                if (mem_wait) begin
                    pipeline_stop = 1'b1;
                    stall_ex      = 1'b1;
                    state_nxt     = ST_MEM;
                end else if (ex_mdu_start) begin
                    pipeline_stop = 1'b1;
                    stall_ex      = 1'b1;
                    mdu_cnt_nxt   = MDU_W'(MDU_LAT - 1);
                    state_nxt     = ST_MDU;
                end else if (ex_br_taken) begin
                    flush_if_id   = 1'b1;
                    flush_id_ex   = 1'b1;
                end else if (load_use) begin
                    pipeline_stop = 1'b1;
                    flush_id_ex   = 1'b1;
                end
            end
            ST_MDU: begin
                if (mdu_cnt != '0) begin
                    pipeline_stop = 1'b1;
                    stall_ex      = 1'b1;
                    mdu_cnt_nxt   = mdu_cnt - MDU_W'(1);
                end else begin
                    state_nxt     = ST_RUN;
                end
            end
            ST_MEM: begin
                if (mem_wait) begin
                    pipeline_stop = 1'b1;
                    stall_ex      = 1'b1;
                end else begin
                    state_nxt     = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
        // Reset drops every stall in the same cycle, whatever the inputs say.
        if (cpu_rst) begin
            pipeline_stop = 1'b0;
            flush_if_id   = 1'b0;
            flush_id_ex   = 1'b0;
            stall_ex      = 1'b0;
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state   <= ST_RUN;
            mdu_cnt <= '0;
        end else begin
            state   <= state_nxt;
            mdu_cnt <= mdu_cnt_nxt;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            stall_cycles <= '0;
        end else if (pipeline_stop && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    assign ctrl_state = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: a cycle-level reference model pushes expected
// outputs, a monitor pops and compares them; a narrow-counter instance exercises saturation.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned MDU_LAT = 8;
    localparam int unsigned SAT_MAX = 7;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic [4:0]  id_rj = '0, id_rk = '0, ex_rd = '0;
    logic        id_rj_used = 1'b0, id_rk_used = 1'b0;
    logic        ex_is_load = 1'b0, ex_wr_en = 1'b0, ex_br_taken = 1'b0, ex_mdu_start = 1'b0;
    logic        mem_req = 1'b0, mem_ack = 1'b0;

    logic        pipeline_stop, flush_if_id, flush_id_ex, stall_ex;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_cycles;
    logic        s_stop, s_fif, s_fie, s_sex;
    logic [1:0]  s_state;
    logic [2:0]  s_cycles;

    pipeline_hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(16)) u_dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .id_rj(id_rj), .id_rk(id_rk),
        .id_rj_used(id_rj_used), .id_rk_used(id_rk_used), .ex_is_load(ex_is_load),
        .ex_wr_en(ex_wr_en), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken),
        .ex_mdu_start(ex_mdu_start), .mem_req(mem_req), .mem_ack(mem_ack),
        .pipeline_stop(pipeline_stop), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .stall_ex(stall_ex), .ctrl_state(ctrl_state), .stall_cycles(stall_cycles)
    );

    pipeline_hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(3)) u_sat (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .id_rj(id_rj), .id_rk(id_rk),
        .id_rj_used(id_rj_used), .id_rk_used(id_rk_used), .ex_is_load(ex_is_load),
        .ex_wr_en(ex_wr_en), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken),
        .ex_mdu_start(ex_mdu_start), .mem_req(mem_req), .mem_ack(mem_ack),
        .pipeline_stop(s_stop), .flush_if_id(s_fif), .flush_id_ex(s_fie),
        .stall_ex(s_sex), .ctrl_state(s_state), .stall_cycles(s_cycles)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct packed {
        logic        stop;
        logic        fif;
        logic        fie;
        logic        sex;
        logic [1:0]  st;
        logic [15:0] cnt;
        logic [2:0]  cnt3;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   pushed   = 0;
    int   popped   = 0;

    // Reference model: mode 0 running, 1 MDU busy, 2 waiting on memory.
    int   m_mode   = 0;
    int   m_tick   = 0;
    int   m_start  = 0;
    int   m_stalls = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // One clock cycle: inputs are already applied at posedge+1.
    task automatic cycle();
        exp_t e;
        bit   lu, mw, stop;
        int   elapsed;
        lu = ex_is_load && ex_wr_en && (ex_rd != 5'd0) &&
             ((id_rj_used && id_rj == ex_rd) || (id_rk_used && id_rk == ex_rd));
        mw = mem_req && !mem_ack;
        e  = '0;
        if (cpu_rst) begin
            m_mode   = 0;
            m_stalls = 0;
        end else begin
            e.st   = 2'(m_mode);
            e.cnt  = (m_stalls > 65535) ? 16'hFFFF : 16'(m_stalls);
            e.cnt3 = (m_stalls > int'(SAT_MAX)) ? 3'(SAT_MAX) : 3'(m_stalls);
            stop   = 1'b0;
            if (m_mode == 0) begin
                if (mw) begin
                    stop = 1'b1; e.sex = 1'b1; m_mode = 2;
                end else if (ex_mdu_start) begin
                    stop = 1'b1; e.sex = 1'b1; m_mode = 1; m_start = m_tick;
                end else if (ex_br_taken) begin
                    e.fif = 1'b1; e.fie = 1'b1;
                end else if (lu) begin
                    stop = 1'b1; e.fie = 1'b1;
                end
            end else if (m_mode == 1) begin
                elapsed = m_tick - m_start;
                if (elapsed < int'(MDU_LAT)) begin
                    stop = 1'b1; e.sex = 1'b1;
                end else begin
                    m_mode = 0;
                end
            end else begin
                if (mw) begin
                    stop = 1'b1; e.sex = 1'b1;
                end else begin
                    m_mode = 0;
                end
            end
            e.stop = stop;
            if (stop) m_stalls++;
        end
        q.push_back(e);
        pushed++;
        m_tick++;
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic idle();
        id_rj = '0; id_rk = '0; ex_rd = '0;
        id_rj_used = 1'b0; id_rk_used = 1'b0;
        ex_is_load = 1'b0; ex_wr_en = 1'b0; ex_br_taken = 1'b0; ex_mdu_start = 1'b0;
        mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge cpu_clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                popped++;
                chk("pipeline_stop", int'(pipeline_stop), int'(e.stop));
                chk("flush_if_id",   int'(flush_if_id),   int'(e.fif));
                chk("flush_id_ex",   int'(flush_id_ex),   int'(e.fie));
                chk("stall_ex",      int'(stall_ex),      int'(e.sex));
                chk("ctrl_state",    int'(ctrl_state),    int'(e.st));
                chk("stall_cycles",  int'(stall_cycles),  int'(e.cnt));
                chk("sat_stall",     int'(s_stop),        int'(e.stop));
                chk("sat_cycles",    int'(s_cycles),      int'(e.cnt3));
                chk("flush_vs_stop", int'(flush_if_id && pipeline_stop), 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t actual=timeout expected=finish", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        bit req_hold;
        idle();
        cpu_rst = 1'b1;
        @(posedge cpu_clk);
        #1;
        run(2);
        cpu_rst = 1'b0;
        run(3);

        // Load-use on rj, then the same with r0 destination (no hazard).
        ex_is_load = 1'b1; ex_wr_en = 1'b1; ex_rd = 5'd5; id_rj = 5'd5; id_rj_used = 1'b1;
        cycle();
        idle(); run(1);
        ex_is_load = 1'b1; ex_wr_en = 1'b1; ex_rd = 5'd0; id_rj = 5'd0; id_rj_used = 1'b1;
        cycle();
        idle(); run(1);

        // Taken branch alone, then with a coincident load-use.
        ex_br_taken = 1'b1; cycle();
        idle(); run(1);
        ex_br_taken = 1'b1;
        ex_is_load = 1'b1; ex_wr_en = 1'b1; ex_rd = 5'd7; id_rk = 5'd7; id_rk_used = 1'b1;
        cycle();
        idle(); run(1);

        // Single MDU op.
        ex_mdu_start = 1'b1; cycle();
        idle(); run(10);

        // Memory wait of three cycles, then ack.
        mem_req = 1'b1; run(3);
        mem_ack = 1'b1; cycle();
        idle(); run(2);

        // Branch held in EX during a memory wait acts only after release.
        mem_req = 1'b1; ex_br_taken = 1'b1; run(3);
        mem_ack = 1'b1; cycle();
        mem_req = 1'b0; mem_ack = 1'b0; cycle();
        idle(); run(1);

        // Memory wait and MDU start together: memory first, then the full MDU stall.
        mem_req = 1'b1; ex_mdu_start = 1'b1; run(2);
        mem_ack = 1'b1; cycle();
        mem_req = 1'b0; mem_ack = 1'b0; cycle();
        ex_mdu_start = 1'b0; run(10);

        // Reset in the fourth MDU stall cycle.
        ex_mdu_start = 1'b1; cycle();
        ex_mdu_start = 1'b0; run(2);
        cpu_rst = 1'b1; cycle();
        cpu_rst = 1'b0; run(2);

        // Randomized traffic with a sticky memory request.
        req_hold = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            id_rj        = 5'($urandom_range(0, 3));
            id_rk        = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            id_rj_used   = 1'($urandom_range(0, 1));
            id_rk_used   = 1'($urandom_range(0, 1));
            ex_is_load   = ($urandom_range(0, 2) == 0);
            ex_wr_en     = ($urandom_range(0, 3) != 0);
            ex_br_taken  = ($urandom_range(0, 4) == 0);
            ex_mdu_start = ($urandom_range(0, 19) == 0);
            if (!req_hold) req_hold = ($urandom_range(0, 7) == 0);
            mem_req = req_hold;
            mem_ack = req_hold && ($urandom_range(0, 2) == 0);
            if (mem_ack || $urandom_range(0, 49) == 0) req_hold = 1'b0;
            cpu_rst = ($urandom_range(0, 499) == 0);
            cycle();
        end
        idle();
        cpu_rst = 1'b0;
        run(2);

        for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge cpu_clk);
        chk("scoreboard_drain", popped, pushed);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage miniLA pipeline. Drives pipeline_stop and flush_if_id into the IF/ID register, plus matching hold/flush controls for later stages. Resolves load-use hazards, taken-branch redirects, multi-cycle MDU (mul/div) occupancy and data-memory wait handshakes with a fixed priority. Keeps a saturating stall-cycle performance counter.

Parameters:
MDU_LAT, 8, total stall cycles for one multi-cycle MDU op; legal range 2..255
CNT_W, 16, width of stall performance counter

Ports:
cpu_clk  in  1  pipeline clock
cpu_rst  in  1  asynchronous active-high reset
id_rj  in  5  ID-stage source register 1
id_rk  in  5  ID-stage source register 2
id_rj_used  in  1  ID instruction reads id_rj
id_rk_used  in  1  ID instruction reads id_rk
ex_is_load  in  1  EX instruction is a load
ex_wr_en  in  1  EX instruction writes the register file
ex_rd  in  5  EX destination register
ex_br_taken  in  1  EX branch/jump resolved taken
ex_mdu_start  in  1  EX holds a multi-cycle MDU op
mem_req  in  1  MEM stage has an outstanding data-memory access
mem_ack  in  1  data memory completes the access this cycle
pipeline_stop  out  1  hold PC and IF/ID
flush_if_id  out  1  clear IF/ID to zero
flush_id_ex  out  1  insert bubble into ID/EX
stall_ex  out  1  hold ID/EX and EX/MEM
ctrl_state  out  2  debug: 0 RUN, 1 MDU, 2 MEM
stall_cycles  out  CNT_W  count of cycles with pipeline_stop=1

Behaviour:
- All control outputs are combinational from the registered state plus current inputs. State, MDU counter and stall_cycles are registered on posedge cpu_clk and cleared asynchronously by cpu_rst.
- Reset: state RUN, mdu_cnt 0, stall_cycles 0. With idle inputs, all control outputs are 0. Reset asserted mid-stall returns to RUN immediately and drops all stalls in that cycle.
- Definitions:
  - load_use = ex_is_load & ex_wr_en & (ex_rd!=0) & ((id_rj_used & id_rj==ex_rd) | (id_rk_used & id_rk==ex_rd)).
  - mem_wait = mem_req & ~mem_ack.
  - full stall = pipeline_stop=1, stall_ex=1, both flushes 0.
- RUN, priority highest first:
  1. mem_wait: full stall; next state MEM.
  2. ex_mdu_start: full stall; mdu_cnt <= MDU_LAT-1; next state MDU.
  3. ex_br_taken: flush_if_id=1, flush_id_ex=1, pipeline_stop=0 so PC loads the target; state stays RUN.
  4. load_use: pipeline_stop=1, flush_id_ex=1, stall_ex=0; one-cycle bubble, no state change.
  5. Otherwise all outputs 0.
- A branch or load-use coincident with mem_wait or an MDU op is suppressed, not lost. EX/ID are held, so the condition is re-evaluated after release.
- MDU state:
  - If mdu_cnt!=0: full stall and decrement mdu_cnt.
  - If mdu_cnt==0: release cycle with all outputs 0; next state RUN.
  - ex_br_taken, load_use and ex_mdu_start are ignored in MDU.
  - Total stall per MDU op is exactly MDU_LAT cycles.
  - mem_wait arising in MDU is handled on return to RUN.
- MEM state:
  - Full stall while mem_ack=0.
  - When mem_ack=1: release cycle with all outputs 0; next state RUN.
  - mem_req dropping without ack is also treated as release (defensive).
- mem_req & mem_ack in the same RUN cycle: no stall.
- stall_cycles increments every cycle pipeline_stop=1 and saturates at all-ones; it never wraps.
- ctrl_state reflects the registered state.
- Invariant: flush_if_id=1 implies pipeline_stop=0. Any violation is a bug; verification asserts it.

Test Plan:
- Load-use: ex_is_load=1, ex_wr_en=1, ex_rd=5, id_rj=5, id_rj_used=1 -> exactly one cycle of pipeline_stop=1, flush_id_ex=1. Same with ex_rd=0 -> no stall.
- Branch: ex_br_taken=1 in RUN -> flush_if_id=1, flush_id_ex=1, pipeline_stop=0 for one cycle. Branch with a simultaneous load_use -> flush only.
- MDU, MDU_LAT=8: ex_mdu_start pulse -> pipeline_stop/stall_ex high exactly 8 consecutive cycles, then RUN. stall_cycles advances by 8.
- Memory wait: mem_req=1 with mem_ack held low 3 cycles, then high -> full stall for those 3 cycles plus 0 on the ack cycle. ex_br_taken=1 during the wait -> no flush until after release.
- Priority: mem_wait and ex_mdu_start together -> MEM first; after ack, the MDU stall of 8 cycles follows.
- Reset mid-MDU (cycle 4) -> outputs 0 immediately, ctrl_state=0, stall_cycles=0. Separately, force stall_cycles to 0xFFFE and stall 3 cycles -> holds at 0xFFFF.
